reg_file: RTL

Eight-entry, 16-bit register file with a latched ALU status register, sitting directly upstream of the 16-bit ALU in the single-cycle datapath. Two asynchronous read ports drive the ALU X/Y operands, one synchronous write port accepts the ALU result for writeback, and a 5-bit flag register captures the ALU's Cout/lt/eq/gt/V outputs and returns the stored carry as the ALU's Cin. Register 0 is hardwired to zero.

---
 rtl/reg_file.sv | 75 +++++++
 1 files changed

// File: rtl/reg_file.sv
// reg_file: eight-entry register file with a latched ALU status register.
// Reads are combinational from stored state only (no write bypass), so the
// ALU result path from ra_data/rb_data back to wr_data cannot form a loop.
// Register 0 has no storage and always reads zero.
module reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic              cout_in,
  input  logic              lt_in,
  input  logic              eq_in,
  input  logic              gt_in,
  input  logic              v_in,
  output logic [4:0]        flags,
  output logic              cin_out,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 1 << ADDR_W;

  // only r1..r(NREG-1) exist as flops
  logic [DATA_W-1:0] regs [1:NREG-1];
  logic [4:0]        flag_q;

  // register writeback; writes to address 0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // status capture, packed as {V, gt, eq, lt, C} with carry in bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= '0;
    end else if (flag_we) begin
      flag_q <= {v_in, gt_in, eq_in, lt_in, cout_in};
    end
  end

  // combinational read ports, r0 forced to zero
  always_comb begin
    ra_data  = '0;
    rb_data  = '0;
    dbg_data = '0;
    if (ra_addr != '0) begin
      ra_data = regs[ra_addr];
    end
    if (rb_addr != '0) begin
      rb_data = regs[rb_addr];
    end
    if (dbg_addr != '0) begin
      dbg_data = regs[dbg_addr];
    end
  end

  assign flags   = flag_q;
  assign cin_out = flag_q[0];

endmodule
